// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and the control unit
// that drives its direction inputs.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam int LANES = 4;

    // Direction encoding as {MemRead, MemWrite}
    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_STORE = 2'b01;
    localparam logic [1:0] DIR_LOAD  = 2'b10;
    localparam logic [1:0] DIR_BOTH  = 2'b11;

    function automatic logic dir_legal(input logic [1:0] dir);
        return (dir == DIR_LOAD) || (dir == DIR_STORE);
    endfunction

endpackage

// File: rtl/lsu_beat_timer.sv
// Per-byte wait counter: counts cycles without mem_ack and flags the last
// permitted cycle so the caller can abort on the next missing ack.
module lsu_beat_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High when one more un-acked cycle would reach TIMEOUT
    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/load_store_unit.sv
// Word load/store stage moving 32-bit data over a byte-wide memory port,
// little-endian, one byte per acknowledged beat.
//
// state | meaning
// IDLE  | ready for a request, no memory strobes
// XFER  | walking bytes 0..3, strobe held until each beat is acked
// DONE  | one-cycle response pulse, then back to IDLE
module load_store_unit #(
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       ALUOut,
    input  logic [31:0]       ReadData2,
    output logic [31:0]       ReadData3,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);
    import lsu_pkg::*;

    localparam logic [1:0] LAST_IDX = 2'(LANES - 1);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              load_q, load_d;
    logic              err_q, err_d;
    logic [1:0]        idx_q, idx_d;

    logic [1:0] dir;
    logic [4:0] lane_lsb;
    logic       in_xfer;
    logic       tmr_clr, tmr_inc, tmr_expired;
    logic       unused_addr_hi;

    assign dir            = {MemRead, MemWrite};
    assign lane_lsb       = {idx_q, 3'b000};
    assign in_xfer        = (state_q == XFER);
    assign unused_addr_hi = ^ALUOut[31:ADDR_W];

    assign tmr_inc = in_xfer && !mem_ack;
    assign tmr_clr = !tmr_inc;

    lsu_beat_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_beat_timer (
        .clk_i     (CLK),
        .rst_n_i   (RESET_N),
        .clr_i     (tmr_clr),
        .inc_i     (tmr_inc),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        err_d   = err_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = ALUOut[ADDR_W-1:0];
                    wdata_d = ReadData2;
                    load_d  = (dir == DIR_LOAD);
                    idx_d   = '0;
                    asm_d   = '0;
                    if (dir_legal(dir) && (ALUOut[1:0] == 2'b00)) begin
                        state_d = XFER;
                        err_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            XFER: begin
                if (mem_ack) begin
                    if (load_q) begin
                        asm_d[lane_lsb +: 8] = mem_rdata;
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        rdata_d = load_q ? asm_d : '0;
                    end
                end else if (tmr_expired) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign stall     = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_err   = rsp_valid && err_q;
    assign ReadData3 = rdata_q;

    // Address and data are forced to zero outside XFER so the port is quiet
    assign mem_re    = in_xfer && load_q;
    assign mem_we    = in_xfer && !load_q;
    assign mem_addr  = in_xfer ? (addr_q + {{(ADDR_W-2){1'b0}}, idx_q}) : '0;
    assign mem_wdata = in_xfer ? wdata_q[lane_lsb +: 8] : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte memory model whose
// ack can be tied high, toggled every other cycle, or held low.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ALUOut;
    logic [31:0] ReadData2;
    logic [31:0] ReadData3;
    logic        rsp_valid;
    logic        rsp_err;
    logic        stall;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:255];
    logic [1:0] ack_mode;
    logic       alt = 1'b0;
    int         strobe_cnt = 0;
    int         stall_low  = 0;

    load_store_unit #(
        .ADDR_W  (20),
        .TIMEOUT (15)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUOut    (ALUOut),
        .ReadData2 (ReadData2),
        .ReadData3 (ReadData3),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .stall     (stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 CLK = ~CLK;

    assign mem_ack   = (ack_mode == 2'd1) || ((ack_mode == 2'd2) && alt);
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge CLK) begin
        alt <= (mem_re || mem_we) ? ~alt : 1'b0;
        if (mem_re || mem_we) strobe_cnt <= strobe_cnt + 1;
        if (mem_we && mem_ack) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Called just after the accepting edge; counts negedges until rsp_valid.
    task automatic wait_rsp(input string tag, output int cyc, output logic [31:0] d, output logic e);
        bit seen = 0;
        cyc = 0;
        d   = '0;
        e   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            cyc++;
            if (!stall) stall_low++;
            if (rsp_valid) begin
                d    = ReadData3;
                e    = rsp_err;
                seen = 1;
                break;
            end
        end
        if (!seen) chk({tag, "_rsp_seen"}, 32'd0, 32'd1);
    endtask

    // Called at a negedge while the unit is idle.
    task automatic do_req(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int cyc, output logic [31:0] d, output logic e);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        MemRead   = rd;
        MemWrite  = wr;
        ALUOut    = addr;
        ReadData2 = wd;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        wait_rsp(tag, cyc, d, e);
        @(negedge CLK);
    endtask

    int          cyc;
    logic [31:0] d;
    logic        e;
    int          s0;
    int          rsp_during_rst;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
        for (int i = 8'h40; i < 8'h44; i++) mem[i] = 8'hEE;

        RESET_N   = 1'b0;
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ALUOut    = '0;
        ReadData2 = '0;
        ack_mode  = 2'd1;

        #2;
        chk("rst_ready",  32'(req_ready), 32'd1);
        chk("rst_stall",  32'(stall),     32'd0);
        chk("rst_rsp",    32'(rsp_valid), 32'd0);
        chk("rst_strobe", 32'({mem_re, mem_we}), 32'd0);
        chk("rst_addr",   32'(mem_addr),  32'd0);
        chk("rst_rdata",  ReadData3,      32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Store with ack tied high
        do_req("st", 1'b0, 1'b1, 32'h10, 32'hA1B2C3D4, cyc, d, e);
        chk("st_lat",   32'(cyc), 32'd5);
        chk("st_err",   32'(e),   32'd0);
        chk("st_rdata", d,        32'd0);
        chk("st_mem",   {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hA1B2C3D4);

        // Load with ack every other cycle
        ack_mode  = 2'd2;
        stall_low = 0;
        do_req("ld_alt", 1'b1, 1'b0, 32'h10, 32'h0, cyc, d, e);
        chk("ld_alt_lat",   32'(cyc),       32'd9);
        chk("ld_alt_data",  d,              32'hA1B2C3D4);
        chk("ld_alt_err",   32'(e),         32'd0);
        chk("ld_alt_stall", 32'(stall_low), 32'd0);
        @(negedge CLK);
        chk("ld_alt_hold",  ReadData3,      32'hA1B2C3D4);

        // Misaligned and illegal direction
        ack_mode = 2'd1;
        s0 = strobe_cnt;
        do_req("misal", 1'b1, 1'b0, 32'h12, 32'h0, cyc, d, e);
        chk("misal_lat",   32'(cyc), 32'd1);
        chk("misal_err",   32'(e),   32'd1);
        chk("misal_rdata", d,        32'd0);
        do_req("both", 1'b1, 1'b1, 32'h20, 32'h0, cyc, d, e);
        chk("both_lat",    32'(cyc), 32'd1);
        chk("both_err",    32'(e),   32'd1);
        chk("illegal_strobes", 32'(strobe_cnt - s0), 32'd0);

        // Timeout with ack held low; previous load result must be cleared
        do_req("ld_pre", 1'b1, 1'b0, 32'h10, 32'h0, cyc, d, e);
        chk("ld_pre_data", d, 32'hA1B2C3D4);
        ack_mode = 2'd0;
        do_req("tmo", 1'b1, 1'b0, 32'h0, 32'h0, cyc, d, e);
        chk("tmo_lat",   32'(cyc), 32'd16);
        chk("tmo_err",   32'(e),   32'd1);
        chk("tmo_rdata", d,        32'd0);
        chk("tmo_ready", 32'(req_ready), 32'd1);

        // Reset in the middle of a store after two bytes
        ack_mode  = 2'd1;
        req_valid = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        ALUOut    = 32'h40;
        ReadData2 = 32'h11223344;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_mid_we_before", 32'(mem_we), 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("rst_mid_strobe", 32'({mem_re, mem_we}), 32'd0);
        chk("rst_mid_stall",  32'(stall),     32'd0);
        chk("rst_mid_ready",  32'(req_ready), 32'd1);
        chk("rst_mid_addr",   32'(mem_addr),  32'd0);
        rsp_during_rst = 0;
        repeat (3) begin
            @(negedge CLK);
            if (rsp_valid) rsp_during_rst++;
        end
        RESET_N = 1'b1;
        @(negedge CLK);
        if (rsp_valid) rsp_during_rst++;
        chk("rst_mid_no_rsp", 32'(rsp_during_rst), 32'd0);
        chk("rst_mid_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'hEEEE3344);
        do_req("ld_after_rst", 1'b1, 1'b0, 32'h40, 32'h0, cyc, d, e);
        chk("ld_after_rst_data", d, 32'hEEEE3344);
        chk("ld_after_rst_lat",  32'(cyc), 32'd5);

        // Back-to-back loads with req_valid held high
        req_valid = 1'b1;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        ALUOut    = 32'h0;
        @(posedge CLK);
        #1;
        ALUOut = 32'h4;
        wait_rsp("b2b0", cyc, d, e);
        chk("b2b0_lat",  32'(cyc), 32'd5);
        chk("b2b0_data", d,        32'h04030201);
        @(negedge CLK);
        chk("b2b_pulse", 32'(rsp_valid), 32'd0);
        chk("b2b_ready", 32'(req_ready), 32'd1);
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        wait_rsp("b2b1", cyc, d, e);
        chk("b2b1_lat",  32'(cyc), 32'd5);
        chk("b2b1_data", d,        32'h08070605);
        chk("b2b1_err",  32'(e),   32'd0);
        @(negedge CLK);
        chk("b2b_idle", 32'(req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage directly downstream of the ALU.
- Accepts one word load or store per request: address from ALUOut, store data from ReadData2, direction from MemRead/MemWrite.
- Moves the word over a byte-wide external memory port, one byte per acknowledged beat, little-endian (byte at address A maps to bits 7:0).
- Returns the assembled load word for the MemtoReg write-back mux and drives a stall that freezes the PC while busy.

Parameters:
ADDR_W, 20, byte-address width of the memory port (1 MB data space)
TIMEOUT, 15, max cycles to wait for mem_ack on one byte before aborting; range 1..255

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET_N  input  1  asynchronous active-low reset
req_valid  input  1  request present this cycle
req_ready  output  1  unit can accept a request
MemRead  input  1  request is a word load
MemWrite  input  1  request is a word store
ALUOut  input  32  byte address; bits above ADDR_W ignored
ReadData2  input  32  store data
ReadData3  output  32  load result, valid while rsp_valid
rsp_valid  output  1  one-cycle pulse, access finished
rsp_err  output  1  qualifies rsp_valid: misaligned, illegal or timed out
stall  output  1  high while an access is in flight
mem_addr  output  ADDR_W  byte address of current beat
mem_wdata  output  8  store byte of current beat
mem_re  output  1  read strobe
mem_we  output  1  write strobe
mem_rdata  input  8  read byte, sampled when mem_ack high
mem_ack  input  1  beat complete

Behaviour:
- Reset (async, RESET_N low): state IDLE; req_ready=1; stall=0; rsp_valid=0; rsp_err=0; ReadData3=0; mem_re=0; mem_we=0; mem_addr=0; mem_wdata=0; byte index=0; timeout counter=0.
- States: IDLE, XFER, DONE.
- IDLE: req_ready=1, stall=0. Acceptance is req_valid=1 sampled at a rising edge. At acceptance the unit latches address, ReadData2 and direction.
  - Exactly one of MemRead/MemWrite high and ALUOut[1:0]==0: go to XFER with byte index 0.
  - Both high, neither high, or ALUOut[1:0]!=0: go to DONE with err=1 and no memory strobe ever issued.
- XFER: stall=1, req_ready=0.
  - mem_addr = latched_addr + index; mem_re/mem_we held high per direction.
  - On an edge with mem_ack=1:
    - Load: mem_rdata is written to byte lane [index].
    - Index increments and the timeout counter clears.
    - When index 3 is acked, go to DONE.
  - On an edge with mem_ack=0: the counter increments. When the counter reaches TIMEOUT, go to DONE with err=1.
  - Strobes are deasserted in the cycle after the final ack.
- DONE (exactly one cycle): rsp_valid=1, rsp_err=err, stall=1, req_ready=0. ReadData3 holds the assembled word for a load and 0 for a store or any error. Next state is IDLE. ReadData3 keeps its value until the next DONE.
- Latency with mem_ack tied high: accept at edge 0, bytes at edges 1–4, rsp_valid high in the cycle following edge 4. Total 5 cycles from acceptance to response.
- Address arithmetic is modulo 2^ADDR_W. An aligned word never crosses a wrap, so no carry out is needed.
- req_valid while not in IDLE is ignored and not queued. The upstream controller must hold the request until req_ready.
- mem_ack outside XFER is ignored.
- Reset mid-operation: strobes drop immediately and no response is issued. Bytes already stored stay written; no rollback.

Decomposition:
- Shared package lsu_pkg holds:
  - the state enumeration (IDLE/XFER/DONE)
  - the byte-lane count constant (4)
  - MemRead/MemWrite direction encoding constants reused by the control unit
- One natural sub-module, lsu_beat_timer: the per-byte timeout counter with clear/increment/expired.
- The FSM, byte index and lane assembly stay in the top module.

Test Plan:
- Store, ack tied high: req_valid=1, MemWrite=1, ALUOut=0x10, ReadData2=0xA1B2C3D4 -> mem_we beats at addr 0x10..0x13 carrying D4,C3,B2,A1; rsp_valid 5 cycles after acceptance; rsp_err=0; ReadData3=0.
- Load with ack every other cycle: memory holds 0x10..0x13 = D4,C3,B2,A1; MemRead=1, ALUOut=0x10 -> ReadData3=0xA1B2C3D4 with rsp_valid after 8 XFER cycles; stall high from acceptance through the DONE cycle.
- Misaligned/illegal: ALUOut=0x12 with MemRead=1, then MemRead=MemWrite=1 at 0x20 -> each gives rsp_valid with rsp_err=1 the cycle after acceptance; mem_re/mem_we never asserted.
- Timeout: load at 0x0, mem_ack held 0 -> after 15 cycles in XFER, rsp_valid=1, rsp_err=1, ReadData3=0; unit returns to IDLE with req_ready=1.
- Reset mid-store: drop RESET_N after 2 bytes acked at 0x40 -> outputs return to reset values immediately, no rsp_valid, bytes 0x40/0x41 written and 0x42/0x43 untouched; a following load is accepted normally.
- Back-to-back: req_valid held high across two loads at 0x0 and 0x4 -> second accepted on the first IDLE edge after DONE; two separate rsp_valid pulses with the correct words.
